// File: rtl/audio_i2s_clkgen.sv
// I2S master-clock front end: divides XCK into BCK/LRCK, requests one stereo
// sample per frame and commits it to stable holding registers once per frame.
module audio_i2s_clkgen #(
  parameter int MCLK_DIV = 4,
  parameter int DW       = 24
) (
  input  logic          iAUD_XCK,
  input  logic          reset_reg_N,
  input  logic          i_enable,
  input  logic          i_sample_valid,
  input  logic [DW-1:0] i_lsample,
  input  logic [DW-1:0] i_rsample,
  output logic          o_sample_req,
  output logic          oAUD_BCK,
  output logic          oAUD_LRCK,
  output logic [DW-1:0] o_lsound_out,
  output logic [DW-1:0] o_rsound_out,
  output logic          o_underrun,
  output logic          o_overrun,
  output logic [7:0]    o_underrun_cnt
);

  localparam logic [7:0] DIV_LAST = 8'(MCLK_DIV - 1);

  logic [7:0]    div_cnt_q, div_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic          bck_q, bck_d;
  logic          lrck_q, lrck_d;
  logic          req_q, req_d;
  logic          pend_flag_q, pend_flag_d;
  logic [DW-1:0] pend_l_q, pend_l_d;
  logic [DW-1:0] pend_r_q, pend_r_d;
  logic [DW-1:0] out_l_q, out_l_d;
  logic [DW-1:0] out_r_q, out_r_d;
  logic          under_q, under_d;
  logic          over_q, over_d;
  logic [7:0]    under_cnt_q, under_cnt_d;

  logic div_tc;
  logic bck_fall;
  logic commit;

  assign div_tc   = (div_cnt_q == DIV_LAST);
  assign bck_fall = i_enable && div_tc && bck_q;
  // Commit mid-way through the left half so both channels of a frame match.
  assign commit   = bck_fall && (bit_cnt_q == 5'd15) && !lrck_q;

  // Handshake: o_sample_req is a one-cycle request; the synth answers later
  // with a one-cycle i_sample_valid strobe carrying the L/R pair. There is no
  // backpressure: a second strobe before the commit overwrites the first.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    bck_d       = bck_q;
    lrck_d      = lrck_q;
    req_d       = 1'b0;
    pend_flag_d = pend_flag_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    under_d     = 1'b0;
    over_d      = 1'b0;
    under_cnt_d = under_cnt_q;

    if (i_enable) begin
      if (div_tc) begin
        div_cnt_d = 8'd0;
        bck_d     = ~bck_q;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
      if (bck_fall) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          lrck_d = ~lrck_q;
          req_d  = !lrck_q;
        end
      end
    end else begin
      div_cnt_d = 8'd0;
      bit_cnt_d = 5'd0;
      bck_d     = 1'b0;
      lrck_d    = 1'b0;
    end

    if (commit) begin
      if (i_sample_valid) begin
        out_l_d     = i_lsample;
        out_r_d     = i_rsample;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        out_l_d     = pend_l_q;
        out_r_d     = pend_r_q;
        pend_flag_d = 1'b0;
      end else begin
        under_d = 1'b1;
        if (under_cnt_q != 8'hFF) under_cnt_d = under_cnt_q + 8'd1;
      end
    end else if (i_sample_valid) begin
      pend_l_d    = i_lsample;
      pend_r_d    = i_rsample;
      pend_flag_d = 1'b1;
      over_d      = pend_flag_q;
    end
  end

  always_ff @(posedge iAUD_XCK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      bck_q       <= 1'b0;
      lrck_q      <= 1'b0;
      req_q       <= 1'b0;
      pend_flag_q <= 1'b0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
      under_cnt_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bck_q       <= bck_d;
      lrck_q      <= lrck_d;
      req_q       <= req_d;
      pend_flag_q <= pend_flag_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      under_q     <= under_d;
      over_q      <= over_d;
      under_cnt_q <= under_cnt_d;
    end
  end

  assign o_sample_req   = req_q;
  assign oAUD_BCK       = bck_q;
  assign oAUD_LRCK      = lrck_q;
  assign o_lsound_out   = out_l_q;
  assign o_rsound_out   = out_r_q;
  assign o_underrun     = under_q;
  assign o_overrun      = over_q;
  assign o_underrun_cnt = under_cnt_q;

endmodule
